// File: rtl/bus_pkg.sv
// Shared constants and FSM state encoding for the bus burst master
// and its write-data FIFO.
package bus_pkg;

    localparam int ADDR_W  = 16;
    localparam int WDATA_W = 32;
    localparam int RDATA_W = 64;
    localparam int LEN_W   = 5;
    localparam int FIFO_AW = 5;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_WAITD = 3'd1;
    localparam state_t S_WR    = 3'd2;
    localparam state_t S_RD    = 3'd3;
    localparam state_t S_DRAIN = 3'd4;
    localparam state_t S_FIN   = 3'd5;

    function automatic logic is_bus_state(input state_t s);
        return (s == S_WR) || (s == S_RD);
    endfunction

endpackage

// File: rtl/bus_wdata_fifo.sv
// Synchronous write-data FIFO with a first-word-fall-through head.
// Pointers and count are reset; storage is not, so reset simply discards contents.
module bus_wdata_fifo #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(2**AW));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/bus_burst_master.sv
// Command-driven incrementing burst initiator: writes FIFO data to the bus
// or streams read data back, one burst per accepted command.
module bus_burst_master
    import bus_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               wd_valid,
    input  logic [WDATA_W-1:0] wd_data,
    output logic               wd_ready,
    output logic               rd_valid,
    output logic [RDATA_W-1:0] rd_data,
    output logic               done,
    output logic               busy,
    output logic               m_req,
    output logic               m_wr,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [WDATA_W-1:0] m_dout,
    input  logic               m_grant,
    input  logic [RDATA_W-1:0] m_din
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_q, cur_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               pend_q, pend_d;

    logic [WDATA_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_AW:0]   fifo_count;
    logic [FIFO_AW:0]   need;
    logic               fifo_pop;

    bus_wdata_fifo #(
        .DW (WDATA_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (wd_valid),
        .push_data (wd_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign need     = (FIFO_AW+1)'(len_q) + (FIFO_AW+1)'(1);
    assign fifo_pop = (state_q == S_WR) & m_grant & ~fifo_empty;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        len_d   = len_q;
        pend_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cur_d   = cmd_addr;
                    rem_d   = cmd_len;
                    len_d   = cmd_len;
                    state_d = cmd_wr ? S_WAITD : S_RD;
                end
            end
            // Wait for the whole burst's data so the write never stalls mid-burst.
            S_WAITD: begin
                if (fifo_count >= need) begin
                    state_d = S_WR;
                end
            end
            S_WR, S_RD: begin
                if (m_grant) begin
                    cur_d  = cur_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    pend_d = (state_q == S_RD);
                    if (rem_q == '0) begin
                        state_d = (state_q == S_WR) ? S_FIN : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pend_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            pend_q  <= pend_d;
        end
    end

    // Bus outputs decode straight from state flops so reset clears them at once.
    assign m_req     = is_bus_state(state_q);
    assign m_wr      = (state_q == S_WR);
    assign m_addr    = m_req ? cur_q : '0;
    assign m_dout    = m_wr ? fifo_head : '0;
    assign rd_valid  = pend_q;
    assign rd_data   = pend_q ? m_din : '0;
    assign done      = (state_q == S_FIN);
    assign busy      = (state_q != S_IDLE);
    assign cmd_ready = (state_q == S_IDLE);
    assign wd_ready  = ~fifo_full;

endmodule

// File: tb/tb_bus_burst_master.sv
// Directed bench for bus_burst_master: table of bursts plus hand-written
// sequences for data starvation and reset mid-burst.
module tb_bus_burst_master;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [15:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic        wd_valid;
    logic [31:0] wd_data;
    logic        wd_ready;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        done;
    logic        busy;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout;
    logic        m_grant;
    logic [63:0] m_din;

    bus_burst_master dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_data   (wd_data),
        .wd_ready  (wd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .busy      (busy),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_dout    (m_dout),
        .m_grant   (m_grant),
        .m_din     (m_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: returns the zero-extended beat address one cycle after a read beat.
    always @(posedge clk) begin
        if (m_req && m_grant && !m_wr) m_din <= {48'h0, m_addr};
        else                           m_din <= 64'hDEAD_BEEF_0000_0000;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [15:0] beat_addr [$];
    logic [31:0] beat_dout [$];
    logic        beat_wr   [$];
    logic [63:0] rd_q      [$];
    int          beats_seen;
    int          done_cnt;
    int          done_cyc;
    int          last_beat_cyc;
    logic        prev_rbeat = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] held_addr;
    logic [31:0] held_dout;
    logic        held_wr;

    // Monitor: a beat is predicted at the negedge and happens at the next posedge.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_rbeat = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("rd_valid_timing", 64'(rd_valid), 64'(prev_rbeat));
            if (rd_valid) rd_q.push_back(rd_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall && m_req) begin
                chk("hold_addr", 64'(m_addr), 64'(held_addr));
                chk("hold_dout", 64'(m_dout), 64'(held_dout));
                chk("hold_wr", 64'(m_wr), 64'(held_wr));
            end
            if (m_req && m_grant) begin
                beat_addr.push_back(m_addr);
                beat_dout.push_back(m_dout);
                beat_wr.push_back(m_wr);
                beats_seen++;
                last_beat_cyc = cyc;
            end
            prev_rbeat = m_req && m_grant && !m_wr;
            prev_stall = m_req && !m_grant;
            held_addr  = m_addr;
            held_dout  = m_dout;
            held_wr    = m_wr;
        end
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [4:0]  len;
        int          gap_beat;
        int          gap_cyc;
        logic [31:0] dbase;
    } vec_t;

    vec_t vecs [7];

    task automatic clear_mon();
        beat_addr.delete();
        beat_dout.delete();
        beat_wr.delete();
        rd_q.delete();
        beats_seen = 0;
        done_cnt   = 0;
    endtask

    // All tasks start and end 2 time units after a rising edge.
    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wd_valid = 1'b1;
            wd_data  = base + 32'(i);
            @(posedge clk); #2;
        end
        wd_valid = 1'b0;
    endtask

    task automatic issue_cmd(input logic wr, input logic [15:0] addr, input logic [4:0] len);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        wd_valid  = 1'b0;
    endtask

    task automatic verify(input vec_t v, input int idx);
        int          nb;
        bit          gapped;
        logic [15:0] ea;
        nb     = int'(v.len) + 1;
        gapped = 1'b0;
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            if (!gapped && v.gap_beat >= 0 && beats_seen == v.gap_beat) begin
                gapped  = 1'b1;
                m_grant = 1'b0;
                repeat (v.gap_cyc) begin
                    @(posedge clk); #2;
                end
                m_grant = 1'b1;
            end
            @(posedge clk); #2;
        end
        repeat (3) @(posedge clk);
        #2;
        chk($sformatf("v%0d done_count", idx), 64'(done_cnt), 64'd1);
        chk($sformatf("v%0d beat_count", idx), 64'(beat_addr.size()), 64'(nb));
        for (int i = 0; i < nb && i < beat_addr.size(); i++) begin
            ea = v.addr + 16'(i);
            chk($sformatf("v%0d beat_addr[%0d]", idx, i), 64'(beat_addr[i]), 64'(ea));
            chk($sformatf("v%0d beat_wr[%0d]", idx, i), 64'(beat_wr[i]), 64'(v.wr));
            if (v.wr) chk($sformatf("v%0d beat_dout[%0d]", idx, i), 64'(beat_dout[i]), 64'(v.dbase + 32'(i)));
        end
        if (v.wr) begin
            chk($sformatf("v%0d rd_count", idx), 64'(rd_q.size()), 64'd0);
        end else begin
            chk($sformatf("v%0d rd_count", idx), 64'(rd_q.size()), 64'(nb));
            for (int i = 0; i < nb && i < rd_q.size(); i++) begin
                ea = v.addr + 16'(i);
                chk($sformatf("v%0d rd_data[%0d]", idx, i), rd_q[i], {48'h0, ea});
            end
        end
        chk($sformatf("v%0d done_latency", idx), 64'(done_cyc - last_beat_cyc), v.wr ? 64'd1 : 64'd2);
        $display("burst %0d: wr=%0d addr=%h beats=%0d seen=%0d rd=%0d done=%0d",
                 idx, v.wr, v.addr, nb, beat_addr.size(), rd_q.size(), done_cnt);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nb;
        nb = int'(v.len) + 1;
        clear_mon();
        if (v.wr) begin
            push_words(v.dbase, nb);
            if (nb == 32) begin
                chk($sformatf("v%0d full_wd_ready", idx), 64'(wd_ready), 64'd0);
                wd_valid = 1'b1;
                wd_data  = 32'hDEAD_0000;
            end
        end
        issue_cmd(v.wr, v.addr, v.len);
        verify(v, idx);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wd_valid  = 1'b0;
        wd_data   = '0;
        m_grant   = 1'b1;

        vecs[0] = '{wr: 1'b1, addr: 16'h0100, len: 5'd9,  gap_beat: -1, gap_cyc: 0, dbase: 32'h0};
        vecs[1] = '{wr: 1'b0, addr: 16'h0100, len: 5'd9,  gap_beat: -1, gap_cyc: 0, dbase: 32'h0};
        vecs[2] = '{wr: 1'b1, addr: 16'h0200, len: 5'd3,  gap_beat: 2,  gap_cyc: 3, dbase: 32'hA0};
        vecs[3] = '{wr: 1'b0, addr: 16'hFFFE, len: 5'd3,  gap_beat: -1, gap_cyc: 0, dbase: 32'h0};
        vecs[4] = '{wr: 1'b1, addr: 16'h0300, len: 5'd0,  gap_beat: -1, gap_cyc: 0, dbase: 32'h55};
        vecs[5] = '{wr: 1'b0, addr: 16'h0400, len: 5'd2,  gap_beat: 1,  gap_cyc: 2, dbase: 32'h0};
        vecs[6] = '{wr: 1'b1, addr: 16'h0500, len: 5'd31, gap_beat: -1, gap_cyc: 0, dbase: 32'h1000};

        repeat (2) @(posedge clk);
        #2;
        chk("reset m_req", 64'(m_req), 64'd0);
        chk("reset m_wr", 64'(m_wr), 64'd0);
        chk("reset m_addr", 64'(m_addr), 64'd0);
        chk("reset m_dout", 64'(m_dout), 64'd0);
        chk("reset rd_valid", 64'(rd_valid), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset wd_ready", 64'(wd_ready), 64'd1);
        reset_n = 1'b1;
        @(posedge clk); #2;
        chk("idle cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Data starvation: burst of 4 with only 2 words available.
        clear_mon();
        push_words(32'h11, 2);
        issue_cmd(1'b1, 16'h0600, 5'd3);
        for (int i = 0; i < 4; i++) begin
            chk("waitd m_req", 64'(m_req), 64'd0);
            chk("waitd busy", 64'(busy), 64'd1);
            chk("waitd cmd_ready", 64'(cmd_ready), 64'd0);
            @(posedge clk); #2;
        end
        push_words(32'h13, 2);
        verify('{wr: 1'b1, addr: 16'h0600, len: 5'd3, gap_beat: -1, gap_cyc: 0, dbase: 32'h11}, 7);

        // Reset during read beat 2, with stale words sitting in the FIFO.
        clear_mon();
        push_words(32'hBAD0, 3);
        issue_cmd(1'b0, 16'h0700, 5'd5);
        for (int c = 0; c < 50 && beats_seen < 2; c++) begin
            @(posedge clk); #2;
        end
        chk("pre-abort m_addr", 64'(m_addr), 64'h0702);
        reset_n = 1'b0;
        #1;
        chk("abort m_req", 64'(m_req), 64'd0);
        chk("abort m_addr", 64'(m_addr), 64'd0);
        chk("abort m_wr", 64'(m_wr), 64'd0);
        chk("abort rd_valid", 64'(rd_valid), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;
        chk("post-reset cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post-reset wd_ready", 64'(wd_ready), 64'd1);
        run_vec('{wr: 1'b1, addr: 16'h0900, len: 5'd1, gap_beat: -1, gap_cyc: 0, dbase: 32'h77}, 8);
        run_vec('{wr: 1'b0, addr: 16'h0800, len: 5'd1, gap_beat: -1, gap_cyc: 0, dbase: 32'h0}, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
